// File: rtl/pinball_pkg.sv
// Shared types for the pinball collision path: bounce source codes,
// hit-vector bit positions and the arbiter state encoding.
package pinball_pkg;

  typedef enum logic [2:0] {
    SRC_NONE    = 3'd0,
    SRC_FLIPPER = 3'd1,
    SRC_TOP     = 3'd2,
    SRC_LEFT    = 3'd3,
    SRC_RIGHT   = 3'd4
  } src_t;

  // hits[] layout: {bottom, right, left, top, flipper}
  localparam int HIT_FLIPPER = 0;
  localparam int HIT_TOP     = 1;
  localparam int HIT_LEFT    = 2;
  localparam int HIT_RIGHT   = 3;
  localparam int HIT_BOTTOM  = 4;
  localparam int HIT_W       = 5;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    HOLDOFF = 2'd2
  } arb_state_t;

  // Decision for one frame: a bounce source, or ball loss
  typedef struct packed {
    src_t src;
    logic lost;
  } prio_t;

endpackage

// File: rtl/collision_prio_enc.sv
// Combinational frame decision: bottom contact means ball loss and masks
// everything else; otherwise the highest-priority bounce source wins.
module collision_prio_enc
  import pinball_pkg::*;
(
  input  logic [HIT_W-1:0] hits,
  output prio_t            res
);

  // Fixed priority: bottom > flipper > top > left > right
  always_comb begin
    res = '{src: SRC_NONE, lost: 1'b0};
    if (hits[HIT_BOTTOM])       res.lost = 1'b1;
    else if (hits[HIT_FLIPPER]) res.src  = SRC_FLIPPER;
    else if (hits[HIT_TOP])     res.src  = SRC_TOP;
    else if (hits[HIT_LEFT])    res.src  = SRC_LEFT;
    else if (hits[HIT_RIGHT])   res.src  = SRC_RIGHT;
  end

endmodule

// File: rtl/collision_arbiter.sv
// Collects per-pixel smiley collision strobes over a frame, issues at most
// one bounce per frame over valid/ready, and holds off for a number of
// frames afterwards so a single contact is never bounced twice.
module collision_arbiter
  import pinball_pkg::*;
#(
  parameter int COOLDOWN_FRAMES = 2,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pause,
  input  logic             startOfFrame,
  input  logic             collisionSmileyBorderTop,
  input  logic             collisionSmileyBorderLeft,
  input  logic             collisionSmileyBorderRight,
  input  logic             collisionSmileyFlipper,
  input  logic             collisionSmileyBorderBottom,
  output logic             bounce_valid,
  input  logic             bounce_ready,
  output src_t             bounce_src,
  output logic             ball_lost,
  output logic [HIT_W-1:0] pending_mask,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_FRAMES);

  arb_state_t       state;
  logic [HIT_W-1:0] hits;
  logic [CNT_W-1:0] cnt;
  logic [HIT_W-1:0] strobes;
  prio_t            dec;

  assign strobes = {collisionSmileyBorderBottom, collisionSmileyBorderRight,
                    collisionSmileyBorderLeft, collisionSmileyBorderTop,
                    collisionSmileyFlipper};

  // Decision is taken on the frame's accumulated hits at the SOF edge,
  // so the result is registered in the same cycle for T+1 latency.
  collision_prio_enc u_prio (
    .hits (hits),
    .res  (dec)
  );

  // FSM, hit accumulator, hold-off counter and all output registers
  always_ff @(posedge clk) begin
    if (reset || pause) begin
      state        <= COLLECT;
      hits         <= '0;
      cnt          <= '0;
      bounce_valid <= 1'b0;
      bounce_src   <= SRC_NONE;
      ball_lost    <= 1'b0;
      pending_mask <= '0;
      busy         <= 1'b0;
    end else begin
      pending_mask <= hits;
      ball_lost    <= 1'b0;
      case (state)
        COLLECT: begin
          if (startOfFrame) begin
            if (dec.lost) begin
              ball_lost <= 1'b1;
              cnt       <= CNT_LOAD;
              hits      <= '0;
              state     <= HOLDOFF;
              busy      <= 1'b1;
            end else if (dec.src != SRC_NONE) begin
              bounce_valid <= 1'b1;
              bounce_src   <= dec.src;
              hits         <= '0;
              state        <= ISSUE;
              busy         <= 1'b1;
            end else begin
              // Strobe on the SOF cycle opens the new frame
              hits <= strobes;
            end
          end else begin
            hits <= hits | strobes;
          end
        end
        ISSUE: begin
          // Strobes and SOF are ignored; wait indefinitely for the taker
          if (bounce_ready) begin
            bounce_valid <= 1'b0;
            bounce_src   <= SRC_NONE;
            cnt          <= CNT_LOAD;
            state        <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          hits <= '0;
          if (cnt == '0) begin
            state <= COLLECT;
            busy  <= 1'b0;
          end else if (startOfFrame) begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= COLLECT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collision_arbiter.sv
// Directed bench for collision_arbiter: one DUT with the default two-frame
// hold-off and one with zero hold-off, sharing the same input stimulus.
module tb_collision_arbiter;

  logic clk = 1'b0;
  logic rst, pause, sof, st_top, st_left, st_right, st_flip, st_bot, ready;

  logic       v2, l2, b2;
  logic [2:0] s2;
  logic [4:0] pm2;
  logic       v0, l0, b0;
  logic [2:0] s0;
  logic [4:0] pm0;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  collision_arbiter #(.COOLDOWN_FRAMES(2), .CNT_W(4)) dut2 (
    .clk(clk), .reset(rst), .pause(pause), .startOfFrame(sof),
    .collisionSmileyBorderTop(st_top), .collisionSmileyBorderLeft(st_left),
    .collisionSmileyBorderRight(st_right), .collisionSmileyFlipper(st_flip),
    .collisionSmileyBorderBottom(st_bot),
    .bounce_valid(v2), .bounce_ready(ready), .bounce_src(s2),
    .ball_lost(l2), .pending_mask(pm2), .busy(b2)
  );

  collision_arbiter #(.COOLDOWN_FRAMES(0), .CNT_W(4)) dut0 (
    .clk(clk), .reset(rst), .pause(pause), .startOfFrame(sof),
    .collisionSmileyBorderTop(st_top), .collisionSmileyBorderLeft(st_left),
    .collisionSmileyBorderRight(st_right), .collisionSmileyFlipper(st_flip),
    .collisionSmileyBorderBottom(st_bot),
    .bounce_valid(v0), .bounce_ready(ready), .bounce_src(s0),
    .ball_lost(l0), .pending_mask(pm0), .busy(b0)
  );

  // Advance one clock; outputs are observed 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    pause = 0; sof = 0; ready = 0;
    st_top = 0; st_left = 0; st_right = 0; st_flip = 0; st_bot = 0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1; tick(); rst = 0; tick();
  endtask

  task automatic test_reset();
    clear_in();
    rst = 1; st_left = 1; ready = 1; sof = 1;
    tick();
    total_cnt++; if (v2 !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", v2); else pass_cnt++;
    total_cnt++; if (s2 !== 3'd0) $display("FAIL reset_src got=%0d exp=0", s2); else pass_cnt++;
    total_cnt++; if (l2 !== 1'b0) $display("FAIL reset_lost got=%0b exp=0", l2); else pass_cnt++;
    total_cnt++; if (pm2 !== 5'b0) $display("FAIL reset_mask got=%b exp=00000", pm2); else pass_cnt++;
    total_cnt++; if (b2 !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", b2); else pass_cnt++;
    clear_in(); rst = 0;
    tick();
    total_cnt++; if (pm2 !== 5'b0 || b2 !== 1'b0 || v2 !== 1'b0)
      $display("FAIL after_reset got mask=%b busy=%0b valid=%0b exp 00000/0/0", pm2, b2, v2); else pass_cnt++;
  endtask

  task automatic test_left_bounce();
    do_reset();
    st_left = 1; tick(); tick(); tick();
    st_left = 0; tick();
    total_cnt++; if (pm2 !== 5'b00100) $display("FAIL left_mask got=%b exp=00100", pm2); else pass_cnt++;
    sof = 1; tick();
    sof = 0; ready = 1;
    total_cnt++; if (v2 !== 1'b1 || s2 !== 3'd3)
      $display("FAIL left_issue got valid=%0b src=%0d exp 1/3", v2, s2); else pass_cnt++;
    tick(); ready = 0;
    total_cnt++; if (v2 !== 1'b0 || s2 !== 3'd0 || b2 !== 1'b1)
      $display("FAIL left_xfer got valid=%0b src=%0d busy=%0b exp 0/0/1", v2, s2, b2); else pass_cnt++;
    // Two hold-off frames with left hits that must be ignored
    st_left = 1; tick(); st_left = 0; tick();
    total_cnt++; if (pm2 !== 5'b0) $display("FAIL holdoff_mask got=%b exp=00000", pm2); else pass_cnt++;
    sof = 1; tick(); sof = 0;
    st_left = 1; tick(); st_left = 0; tick();
    sof = 1; tick(); sof = 0;
    total_cnt++; if (v2 !== 1'b0 || b2 !== 1'b1)
      $display("FAIL holdoff_end got valid=%0b busy=%0b exp 0/1", v2, b2); else pass_cnt++;
    tick();
    total_cnt++; if (b2 !== 1'b0) $display("FAIL holdoff_exit got busy=%0b exp=0", b2); else pass_cnt++;
    st_top = 1; tick(); st_top = 0; tick();
    total_cnt++; if (pm2 !== 5'b00010) $display("FAIL resume_mask got=%b exp=00010", pm2); else pass_cnt++;
  endtask

  task automatic test_flip_top();
    int seen_top;
    do_reset();
    st_flip = 1; st_top = 1; tick();
    st_flip = 0; st_top = 0; tick();
    sof = 1; tick(); sof = 0; ready = 1;
    total_cnt++; if (v2 !== 1'b1 || s2 !== 3'd1)
      $display("FAIL flip_issue got valid=%0b src=%0d exp 1/1", v2, s2); else pass_cnt++;
    tick(); ready = 0;
    seen_top = 0;
    for (int i = 0; i < 16; i++) begin
      sof = (i % 4 == 3);
      ready = 1;
      tick();
      if (v2 === 1'b1) seen_top++;
    end
    clear_in();
    total_cnt++; if (seen_top !== 0) $display("FAIL top_dropped got issues=%0d exp=0", seen_top); else pass_cnt++;
  endtask

  task automatic test_bottom();
    do_reset();
    st_bot = 1; st_flip = 1; tick();
    st_bot = 0; st_flip = 0;
    sof = 1; tick(); sof = 0;
    total_cnt++; if (l2 !== 1'b1 || v2 !== 1'b0 || b2 !== 1'b1)
      $display("FAIL bottom_lost got lost=%0b valid=%0b busy=%0b exp 1/0/1", l2, v2, b2); else pass_cnt++;
    tick();
    total_cnt++; if (l2 !== 1'b0 || v2 !== 1'b0 || b2 !== 1'b1)
      $display("FAIL bottom_pulse got lost=%0b valid=%0b busy=%0b exp 0/0/1", l2, v2, b2); else pass_cnt++;
  endtask

  task automatic test_ready_stall();
    int bad;
    do_reset();
    st_top = 1; tick(); st_top = 0; tick();
    sof = 1; tick(); sof = 0;
    total_cnt++; if (v2 !== 1'b1 || s2 !== 3'd2)
      $display("FAIL stall_issue got valid=%0b src=%0d exp 1/2", v2, s2); else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      sof = (i == 3 || i == 7);
      st_flip = (i % 2 == 0);
      st_left = (i % 3 == 0);
      st_bot  = (i == 5);
      tick();
      if (v2 !== 1'b1 || s2 !== 3'd2 || pm2 !== 5'b0) bad++;
    end
    clear_in();
    total_cnt++; if (bad !== 0) $display("FAIL stall_stable got bad_cycles=%0d exp=0", bad); else pass_cnt++;
    ready = 1; tick(); ready = 0;
    total_cnt++; if (v2 !== 1'b0 || s2 !== 3'd0)
      $display("FAIL stall_xfer got valid=%0b src=%0d exp 0/0", v2, s2); else pass_cnt++;
  endtask

  task automatic test_cooldown0();
    do_reset();
    st_right = 1; tick(); st_right = 0; tick();
    sof = 1; tick(); sof = 0; ready = 1;
    total_cnt++; if (v0 !== 1'b1 || s0 !== 3'd4)
      $display("FAIL cd0_issue got valid=%0b src=%0d exp 1/4", v0, s0); else pass_cnt++;
    tick(); ready = 0;
    total_cnt++; if (v0 !== 1'b0 || b0 !== 1'b1)
      $display("FAIL cd0_xfer got valid=%0b busy=%0b exp 0/1", v0, b0); else pass_cnt++;
    tick();
    total_cnt++; if (b0 !== 1'b0) $display("FAIL cd0_collect got busy=%0b exp=0", b0); else pass_cnt++;
    st_right = 1; tick(); st_right = 0;
    sof = 1; tick(); sof = 0;
    total_cnt++; if (v0 !== 1'b1 || s0 !== 3'd4)
      $display("FAIL cd0_reissue got valid=%0b src=%0d exp 1/4", v0, s0); else pass_cnt++;
  endtask

  task automatic test_pause_reset();
    do_reset();
    st_left = 1; tick(); st_left = 0;
    sof = 1; tick(); sof = 0;
    total_cnt++; if (v2 !== 1'b1) $display("FAIL pause_pre got valid=%0b exp=1", v2); else pass_cnt++;
    pause = 1; st_top = 1; tick(); pause = 0; st_top = 0;
    total_cnt++; if (v2 !== 1'b0 || s2 !== 3'd0 || pm2 !== 5'b0 || b2 !== 1'b0)
      $display("FAIL pause_flush got valid=%0b src=%0d mask=%b busy=%0b exp 0/0/00000/0", v2, s2, pm2, b2); else pass_cnt++;
    st_flip = 1; tick(); st_flip = 0; tick();
    total_cnt++; if (pm2 !== 5'b00001) $display("FAIL pause_collect got mask=%b exp=00001", pm2); else pass_cnt++;
    // Bottom contact into hold-off, then reset mid-HOLDOFF
    st_bot = 1; tick(); st_bot = 0;
    sof = 1; tick(); sof = 0; tick();
    total_cnt++; if (b2 !== 1'b1) $display("FAIL reset_pre got busy=%0b exp=1", b2); else pass_cnt++;
    rst = 1; tick(); rst = 0;
    total_cnt++; if (v2 !== 1'b0 || s2 !== 3'd0 || pm2 !== 5'b0 || b2 !== 1'b0 || l2 !== 1'b0)
      $display("FAIL reset_holdoff got valid=%0b src=%0d mask=%b busy=%0b lost=%0b exp 0/0/00000/0/0", v2, s2, pm2, b2, l2); else pass_cnt++;
    // Reset and pause together while issuing
    st_top = 1; tick(); st_top = 0;
    sof = 1; tick(); sof = 0;
    rst = 1; pause = 1; tick(); rst = 0; pause = 0;
    total_cnt++; if (v2 !== 1'b0 || s2 !== 3'd0 || b2 !== 1'b0)
      $display("FAIL reset_pause got valid=%0b src=%0d busy=%0b exp 0/0/0", v2, s2, b2); else pass_cnt++;
  endtask

  initial begin
    clear_in();
    rst = 1;
    test_reset();
    test_left_bounce();
    test_flip_top();
    test_bottom();
    test_ready_stall();
    test_cooldown0();
    test_pause_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
